// File: rtl/bus_resp_router_pkg.sv
// Shared interconnect definitions: core count, grant encoding and data width
// common to the request-side bus mux and the response router.
package bus_resp_router_pkg;
  localparam int NCORE  = 4;
  localparam int GNT_W  = NCORE;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  typedef logic [ID_W-1:0]   core_id_t;
  typedef logic [GNT_W-1:0]  grant_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/bus_resp_router_if.sv
// Request-issue / response-return bundle between the arbiter/memory side
// (master) and the response router (slave).
interface bus_resp_router_if
  import bus_resp_router_pkg::*;
  #(parameter int DEPTH = 4)
  ();
  localparam int OCC_W = $clog2(DEPTH) + 1;

  grant_t            grant;
  logic              mem_req_valid;
  logic              req_ready;
  logic              mem_rvalid;
  data_t             mem_rdata;
  grant_t            core_rvalid;
  data_t             core_rdata;
  logic [OCC_W-1:0]  outstanding;
  logic              err_orphan;
  logic              err_grant;

  modport master (
    output grant, mem_req_valid, mem_rvalid, mem_rdata,
    input  req_ready, core_rvalid, core_rdata, outstanding, err_orphan, err_grant
  );

  modport slave (
    input  grant, mem_req_valid, mem_rvalid, mem_rdata,
    output req_ready, core_rvalid, core_rdata, outstanding, err_orphan, err_grant
  );
endinterface

// File: rtl/bus_resp_router_id_fifo.sv
// In-order FIFO of requester IDs. Callers never push when full nor pop when
// empty; pointers wrap naturally because DEPTH is a power of two.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = push_i ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop_i  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries below count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
endmodule

// File: rtl/bus_resp_router.sv
// Routes in-order memory responses back to the core that issued each request,
// tracking requester IDs in a FIFO and flagging orphan responses / bad grants.
module bus_resp_router
  import bus_resp_router_pkg::*;
  #(
    parameter int DEPTH = 4,
    parameter int NCORE = bus_resp_router_pkg::NCORE
  ) (
    input  logic              clk,
    input  logic              rst_n,
    bus_resp_router_if.slave  bus
  );
  localparam int OCC_W = $clog2(DEPTH) + 1;

  function automatic logic is_onehot(input grant_t g);
    return (g != '0) && ((g & (g - grant_t'(1))) == '0);
  endfunction

  function automatic core_id_t to_index(input grant_t g);
    core_id_t idx;
    idx = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (g[i]) idx = core_id_t'(i);
    end
    return idx;
  endfunction

  logic              push_ok, pop_ok, gnt_onehot;
  core_id_t          push_id, head_id;
  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  fifo_count;

  grant_t core_rvalid_q, core_rvalid_d;
  data_t  core_rdata_q,  core_rdata_d;
  logic   err_orphan_q,  err_orphan_d;
  logic   err_grant_q,   err_grant_d;

  // Pop eligibility looks only at registered occupancy, so a push into an
  // empty FIFO can never be forwarded by a response in the same cycle.
  always_comb begin
    gnt_onehot = is_onehot(bus.grant);
    push_id    = to_index(bus.grant);
    push_ok    = bus.mem_req_valid & ~fifo_full & gnt_onehot;
    pop_ok     = bus.mem_rvalid & ~fifo_empty;
  end

  id_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .din_i   (push_id),
    .pop_i   (pop_ok),
    .dout_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    core_rvalid_d = pop_ok ? (grant_t'(1) << head_id) : '0;
    core_rdata_d  = pop_ok ? bus.mem_rdata : core_rdata_q;
    err_orphan_d  = err_orphan_q | (bus.mem_rvalid & fifo_empty);
    err_grant_d   = err_grant_q  | (bus.mem_req_valid & ~fifo_full & ~gnt_onehot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid_q <= '0;
      core_rdata_q  <= '0;
      err_orphan_q  <= 1'b0;
      err_grant_q   <= 1'b0;
    end else begin
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      err_orphan_q  <= err_orphan_d;
      err_grant_q   <= err_grant_d;
    end
  end

  assign bus.req_ready   = ~fifo_full;
  assign bus.outstanding = fifo_count;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.err_orphan  = err_orphan_q;
  assign bus.err_grant   = err_grant_q;
endmodule
